// File: rtl/flash_bus_bridge_if.sv
// CPU-bus and SPI-controller signal bundle for flash_bus_bridge.
// The slave modport is the bridge's view; the master modport is the CPU/controller side.
interface flash_bus_bridge_if;
  logic [15:0] i_ADDRESS_BUS;
  logic [7:0]  i_DataBus;
  logic        i_RW;
  logic        i_VMA;
  logic        o_MRDY;
  logic [7:0]  o_DataBus;
  logic        o_DataOE;
  logic        o_spi_ce;
  logic [15:0] o_spi_addr;
  logic [7:0]  o_spi_wdata;
  logic        o_spi_rw;
  logic [7:0]  i_spi_data;
  logic        i_MemoryReady;
  logic        o_timeout;

  modport slave (
    input  i_ADDRESS_BUS, i_DataBus, i_RW, i_VMA, i_spi_data, i_MemoryReady,
    output o_MRDY, o_DataBus, o_DataOE, o_spi_ce, o_spi_addr, o_spi_wdata,
           o_spi_rw, o_timeout
  );

  modport master (
    output i_ADDRESS_BUS, i_DataBus, i_RW, i_VMA, i_spi_data, i_MemoryReady,
    input  o_MRDY, o_DataBus, o_DataOE, o_spi_ce, o_spi_addr, o_spi_wdata,
           o_spi_rw, o_timeout
  );
endinterface

// File: rtl/flash_bus_bridge.sv
// CPU front end for spi_flash_controller: window decode, cycle stretching,
// request timeout and a one-entry read cache.
module flash_bus_bridge #(
  parameter logic [15:0] WIN_MASK       = 16'hF000,
  parameter logic [15:0] WIN_MATCH      = 16'h3000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          CACHE_EN       = 1'b1
) (
  input logic              clk,
  input logic              reset,
  flash_bus_bridge_if.slave bus
);
  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_spi_ce, w_spi_ce_nxt;
  logic [15:0]   r_spi_addr, w_spi_addr_nxt;
  logic [7:0]    r_spi_wdata, w_spi_wdata_nxt;
  logic          r_spi_rw, w_spi_rw_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_oe, w_oe_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic          r_cache_valid, w_cache_valid_nxt;
  logic [15:0]   r_cache_tag, w_cache_tag_nxt;
  logic [7:0]    r_cache_data, w_cache_data_nxt;
  logic          r_from_cache, w_from_cache_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic          w_hit, w_cache_hit;
  logic [15:0]   w_hold_addr;

  always_comb begin
    w_hit       = bus.i_VMA && ((bus.i_ADDRESS_BUS & WIN_MASK) == WIN_MATCH);
    w_cache_hit = CACHE_EN && r_cache_valid && bus.i_RW && (r_cache_tag == bus.i_ADDRESS_BUS);
    // A HOLD entered from the cache has no latched request address; compare the tag instead.
    w_hold_addr = r_from_cache ? r_cache_tag : r_spi_addr;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_spi_ce_nxt      = r_spi_ce;
    w_spi_addr_nxt    = r_spi_addr;
    w_spi_wdata_nxt   = r_spi_wdata;
    w_spi_rw_nxt      = r_spi_rw;
    w_data_nxt        = r_data;
    w_oe_nxt          = r_oe;
    w_timeout_nxt     = r_timeout;
    w_cache_valid_nxt = r_cache_valid;
    w_cache_tag_nxt   = r_cache_tag;
    w_cache_data_nxt  = r_cache_data;
    w_from_cache_nxt  = r_from_cache;
    w_cnt_nxt         = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          if (w_cache_hit) begin
            w_data_nxt       = r_cache_data;
            w_oe_nxt         = 1'b1;
            w_from_cache_nxt = 1'b1;
            w_state_nxt      = HOLD;
          end else begin
            w_spi_addr_nxt   = bus.i_ADDRESS_BUS;
            w_spi_wdata_nxt  = bus.i_DataBus;
            w_spi_rw_nxt     = bus.i_RW;
            w_spi_ce_nxt     = 1'b1;
            w_cnt_nxt        = '0;
            w_from_cache_nxt = 1'b0;
            w_state_nxt      = REQ;
            if (!bus.i_RW && (r_cache_tag == bus.i_ADDRESS_BUS))
              w_cache_valid_nxt = 1'b0;
          end
        end
      end
      REQ: begin
        // Ready is tested first so it wins over a coincident timeout.
        if (bus.i_MemoryReady) begin
          w_spi_ce_nxt = 1'b0;
          if (r_spi_rw) begin
            w_data_nxt        = bus.i_spi_data;
            w_oe_nxt          = 1'b1;
            w_cache_tag_nxt   = r_spi_addr;
            w_cache_data_nxt  = bus.i_spi_data;
            w_cache_valid_nxt = 1'b1;
          end
          w_state_nxt = HOLD;
        end else if (r_cnt == CNT_LAST) begin
          w_spi_ce_nxt  = 1'b0;
          w_timeout_nxt = 1'b1;
          if (r_spi_rw) begin
            w_data_nxt = 8'hFF;
            w_oe_nxt   = 1'b1;
          end
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!w_hit || (bus.i_ADDRESS_BUS != w_hold_addr)) begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_spi_ce      <= 1'b0;
      r_spi_addr    <= '0;
      r_spi_wdata   <= '0;
      r_spi_rw      <= 1'b1;
      r_data        <= '1;
      r_oe          <= 1'b0;
      r_timeout     <= 1'b0;
      r_cache_valid <= 1'b0;
      r_cache_tag   <= '0;
      r_cache_data  <= '0;
      r_from_cache  <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_spi_ce      <= w_spi_ce_nxt;
      r_spi_addr    <= w_spi_addr_nxt;
      r_spi_wdata   <= w_spi_wdata_nxt;
      r_spi_rw      <= w_spi_rw_nxt;
      r_data        <= w_data_nxt;
      r_oe          <= w_oe_nxt;
      r_timeout     <= w_timeout_nxt;
      r_cache_valid <= w_cache_valid_nxt;
      r_cache_tag   <= w_cache_tag_nxt;
      r_cache_data  <= w_cache_data_nxt;
      r_from_cache  <= w_from_cache_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    bus.o_MRDY = !reset || !(w_hit && (((r_state == IDLE) && !w_cache_hit) || (r_state == REQ)));
  end

  assign bus.o_spi_ce    = r_spi_ce;
  assign bus.o_spi_addr  = r_spi_addr;
  assign bus.o_spi_wdata = r_spi_wdata;
  assign bus.o_spi_rw    = r_spi_rw;
  assign bus.o_DataBus   = r_data;
  assign bus.o_DataOE    = r_oe;
  assign bus.o_timeout   = r_timeout;
endmodule

// File: doc/flash_bus_bridge.md
Name: flash_bus_bridge

Overview:
- CPU-side front end for spi_flash_controller.
- Decodes CPU bus cycles that fall in the flash address window and drives the controller's spi_ce / address / data / RW request.
- Stretches the CPU cycle via o_MRDY until the controller reports o_MemoryReady.
- Returns read data to the CPU data bus; a one-entry read cache avoids repeating an SPI transaction for back-to-back reads of the same address.

Parameters:
- WIN_MASK, 16'hF000, address bits compared for window decode.
- WIN_MATCH, 16'h3000, required value of (address & WIN_MASK) for a hit.
- TIMEOUT_CYCLES, 1024, clk cycles in REQ before the request is abandoned.
- CACHE_EN, 1, 1 enables the one-entry read cache; 0 forces every read to the controller.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_ADDRESS_BUS  in  16  CPU address.
- i_DataBus  in  8  CPU write data.
- i_RW  in  1  CPU direction; 1 = read, 0 = write.
- i_VMA  in  1  CPU valid-memory-address qualifier.
- o_MRDY  out  1  1 = CPU may complete the cycle; 0 = stretch.
- o_DataBus  out  8  read data to CPU.
- o_DataOE  out  1  1 = bridge drives o_DataBus onto the CPU bus.
- o_spi_ce  out  1  request to controller (spi_ce).
- o_spi_addr  out  16  address to controller (i_ADDRESS_BUS).
- o_spi_wdata  out  8  write data to controller (i_DataBus).
- o_spi_rw  out  1  direction to controller (i_RW).
- i_spi_data  in  8  controller read data (o_spi_data).
- i_MemoryReady  in  1  controller completion (o_MemoryReady).
- o_timeout  out  1  sticky error flag; set on a request timeout.

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE; o_spi_ce=0; o_spi_addr=0; o_spi_wdata=0; o_spi_rw=1;
  - o_DataBus=8'hFF; o_DataOE=0; o_timeout=0;
  - cache invalid; timeout counter=0.
- Reset mid-transaction aborts immediately. o_spi_ce falls asynchronously; the controller is not waited on.
- hit = i_VMA & ((i_ADDRESS_BUS & WIN_MASK) == WIN_MATCH).
- o_MRDY is combinational: 0 when hit & state is IDLE or REQ, excluding a cache hit in IDLE; 1 otherwise, including during reset.
- IDLE, hit, read, CACHE_EN, cache valid, tag == address:
  - o_DataBus <= cached data; o_DataOE <= 1; -> HOLD.
  - o_MRDY is high in the decode cycle; data is valid from the next edge.
- IDLE, hit, other cases:
  - latch o_spi_addr <= i_ADDRESS_BUS, o_spi_wdata <= i_DataBus, o_spi_rw <= i_RW;
  - o_spi_ce <= 1; counter cleared; -> REQ.
  - o_spi_ce is high one edge after decode.
  - For a write, if tag == address, the cache is invalidated at this edge.
- REQ: o_spi_ce, o_spi_addr, o_spi_wdata and o_spi_rw are held stable; counter increments each cycle.
  - i_MemoryReady=1 at an edge:
    - o_spi_ce <= 0.
    - Read: o_DataBus <= i_spi_data, o_DataOE <= 1, cache tag/data <= o_spi_addr/i_spi_data, cache valid <= 1.
    - -> HOLD.
  - Counter reaches TIMEOUT_CYCLES-1 without ready:
    - o_spi_ce <= 0; o_timeout <= 1.
    - Read: o_DataBus <= 8'hFF, o_DataOE <= 1; cache untouched.
    - -> HOLD.
  - Ready and timeout on the same edge: ready wins; o_timeout is not set.
- HOLD: o_MRDY=1. Leave to IDLE when i_VMA=0, or address leaves the window, or address != o_spi_addr (or != cached tag on a hit path).
  - On leaving: o_DataOE <= 0; o_DataBus holds its value.
  - Guarantees o_spi_ce is low for at least 2 cycles between requests.
- i_MemoryReady is ignored outside REQ.
- Changes to i_RW, address or data while in REQ do not alter the latched request.
- o_timeout clears only on reset.
- Miss-read latency: decode edge + controller latency + 1 edge to o_MRDY=1.

Test Plan:
- Reset: hold reset=0 with hit stimulus at 0x3AAA -> o_spi_ce=0, o_DataOE=0, o_DataBus=FF, o_timeout=0, o_MRDY=1. Release reset -> o_spi_ce rises one edge later.
- Miss read at 0x3AAA: model returns ready after 70 cycles with data 8'hFA -> o_MRDY low for 71 cycles; o_DataBus=FA with o_DataOE=1; o_spi_ce low after the ready edge. Drop i_VMA -> o_DataOE=0.
- Repeat read at 0x3AAA -> no o_spi_ce pulse; o_MRDY never low; o_DataBus=FA one edge after decode.
- Write 0x3AAA <= 8'hAA, then read 0x3AAA -> the write issues o_spi_ce with o_spi_rw=0 and o_spi_wdata=AA. The read misses the cache (new o_spi_ce pulse) and returns the model's new data.
- Out-of-window read at 0x4000, and in-window read with i_VMA=0 -> o_spi_ce stays 0; o_MRDY stays 1.
- Timeout: read 0x3000 with the model never asserting ready -> after 1024 cycles o_spi_ce=0, o_timeout=1 (sticky), o_DataBus=FF, o_MRDY=1. A ready pulse arriving in HOLD has no effect.
